de1_input_conditioner: RTL and testbench
========================================

Name: de1_input_conditioner

Overview:
- Conditions raw DE1 board inputs (SW[7:0] slide switches, KEY[3:0] active-low pushbuttons) before they reach the switch PIO and button-interrupt path of the DE1 system.
- Per input: two-flop synchroniser, then a debounce counter.
- Drives debounced switch levels to switch_pio_external_connection_export.
- Generates one-cycle key-press pulses, sticky pending flags and a maskable level interrupt with per-key acknowledge.

Parameters:
- N_SW, 8, number of slide-switch channels.
- N_KEY, 4, number of pushbutton channels.
- DEBOUNCE_CYCLES, 50000, consecutive stable samples needed to accept a new level (1 ms at 50 MHz); legal range is 1 to 2^20-1.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_clk  in  1  system clock, single domain.
- reset_reset  in  1  asynchronous, active-high reset.
- sw_raw  in  N_SW  raw slide switches, asynchronous to clk_clk.
- key_raw_n  in  N_KEY  raw pushbuttons, active-low, asynchronous.
- key_irq_mask  in  N_KEY  1 enables the key's pending flag onto key_irq.
- key_ack  in  N_KEY  one-cycle pulse that clears the matching pending flag.
- sw_stable  out  N_SW  debounced switch levels, feeds the switch PIO.
- sw_change_pulse  out  N_SW  one cycle high when the matching sw_stable bit toggles.
- key_pressed  out  N_KEY  debounced key state, active-high (1 = held).
- key_press_pulse  out  N_KEY  one cycle high on a debounced press (release does not pulse).
- key_pending  out  N_KEY  sticky press flags.
- key_irq  out  1  OR over (key_pending & key_irq_mask).

Behaviour:
- Reset (asynchronous, active-high). All of the following take these values immediately:
  - sw_stable=0, sw_change_pulse=0
  - key_pressed=0, key_press_pulse=0, key_pending=0, key_irq=0
  - switch synchroniser flops=0
  - key synchroniser flops=1 (released)
  - all counters=0
- Synchroniser: s1<=raw, s2<=s1 on every edge. Key channels are inverted after s2, so internal level 1 means pressed.
- Debounce, per channel, evaluated at each rising edge using the internal level (s2, or inverted s2 for keys) and stable:
  - If level==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=level, cnt<=0, and the channel's transition strobe fires this edge.
  - Else: cnt<=cnt+1.
- Latency: stable updates on the (DEBOUNCE_CYCLES+1)th rising edge after the edge that first samples the new raw level into s1.
- Bounce rejection: any return to the old level before acceptance zeroes cnt. Acceptance needs DEBOUNCE_CYCLES consecutive differing samples.
- Pulses are registered: high exactly one cycle, coincident with the cycle the new stable value is first visible.
  - sw_change_pulse fires on either edge of the switch.
  - key_press_pulse fires on the 0->1 transition of key_pressed only.
- Pending flag, per key, next value = (pending & ~key_ack) | press_strobe. A press and an ack on the same bit in the same cycle leaves the flag set, so no event is lost.
- key_irq is registered from next pending & key_irq_mask, so it is valid one cycle after the strobe.
  - Mask changes affect key_irq one cycle later.
  - Masking never clears key_pending.
- key_ack on a bit with no pending flag has no effect.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse and flag.
- DEBOUNCE_CYCLES=1: accept on the first differing s2 sample (latency 2 edges).
- Reset asserted mid-count discards partial counts and pending flags. After release the debounce restarts from the reset levels, so a key held through reset is reported as a fresh press after DEBOUNCE_CYCLES+1 edges.

Decomposition:
- Package de1_io_pkg holds:
  - N_SW, N_KEY, DEBOUNCE_CYCLES_DEFAULT, CNT_W
  - a clog2 helper for CNT_W checks
- Sub-module debounce_bit contains one channel: synchroniser, counter, stable register and transition strobe, with a parameter for the reset level and an invert option.
- The top instantiates debounce_bit N_SW+N_KEY times and adds the pending/irq logic.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset check: hold reset_reset with key_raw_n=4'hF and sw_raw=8'hA5, then release. Required: all outputs 0 during reset. sw_stable=8'hA5 on the 5th edge after s1 first samples it; key_pressed stays 0.
- Clean press: drive key_raw_n[2]=0 and hold. Required: key_pressed[2]=1 and key_press_pulse[2]=1 for exactly one cycle, 5 edges after the first sampling edge. key_pending[2]=1; key_irq=1 one cycle later with mask=4'hF.
- Bounce rejection: toggle sw_raw[0] 0->1 for 3 cycles, back to 0 for 1 cycle, then 1 and held. Required: no change during the bounce. sw_stable[0]=1 with sw_change_pulse[0] 5 edges after the final transition is sampled.
- Ack/press collision: with key_pending[1]=1, pulse key_ack[1] in the same cycle as a new press strobe on key 1. Required: key_pending[1] stays 1. A later lone ack clears it and key_irq drops the following cycle.
- Masking: key_irq_mask=4'h0 with a press on key 3. Required: key_pending[3]=1 and key_irq=0. Set mask[3]=1 and key_irq=1 one cycle later.
- Reset mid-count: key 0 held with cnt=2 and reset pulsed. Required: outputs cleared; a fresh press is reported 5 edges after release.

Source files
------------

// File: rtl/de1_io_pkg.sv
// de1_io_pkg
//   Shared sizing constants for the DE1 input conditioner and a ceiling-log2
//   helper used to confirm that the debounce counter is wide enough.
//   No ports (package).
package de1_io_pkg;

    localparam int N_SW                    = 8;
    localparam int N_KEY                   = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;   // 1 ms at 50 MHz
    localparam int CNT_W                   = 20;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit
//   One conditioned input channel: two-flop synchroniser, optional inversion,
//   debounce counter, accepted (stable) level and a registered one-cycle
//   transition pulse that is high in the same cycle the new stable value is
//   first visible.
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   raw     in   raw pin, asynchronous to clk
//   stable  out  debounced level (internal sense, after optional inversion)
//   pulse   out  one-cycle strobe on acceptance (rising only if RISE_ONLY)
module debounce_bit
    import de1_io_pkg::*;
#(
    parameter int   CYCLES     = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   WIDTH      = CNT_W,
    parameter logic SYNC_RESET = 1'b0,   // synchroniser reset value (raw sense)
    parameter logic INVERT     = 1'b0,   // 1 for active-low pins
    parameter logic RISE_ONLY  = 1'b0    // 1: pulse only on 0->1 acceptance
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic pulse
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             level;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= SYNC_RESET;
            s2 <= SYNC_RESET;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign level = s2 ^ INVERT;

    // Any sample equal to the accepted level restarts the count, so only an
    // unbroken run of CYCLES differing samples is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (level == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= level;
                cnt    <= '0;
                pulse  <= RISE_ONLY ? level : 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/de1_input_conditioner.sv
// de1_input_conditioner
//   Conditions DE1 slide switches and active-low pushbuttons: each pin gets a
//   synchroniser and debouncer; keys additionally produce sticky pending
//   flags and a maskable level interrupt with per-key acknowledge.
// Ports
//   clk_clk          in   system clock
//   reset_reset      in   asynchronous active-high reset
//   sw_raw           in   raw slide switches
//   key_raw_n        in   raw pushbuttons, active-low
//   key_irq_mask     in   1 routes the key's pending flag onto key_irq
//   key_ack          in   one-cycle pulse clearing the matching pending flag
//   sw_stable        out  debounced switch levels (switch PIO)
//   sw_change_pulse  out  one cycle high when the sw_stable bit toggles
//   key_pressed      out  debounced key state, 1 = held
//   key_press_pulse  out  one cycle high on a debounced press
//   key_pending      out  sticky press flags
//   key_irq          out  OR over (key_pending & key_irq_mask), registered
module de1_input_conditioner #(
    parameter int N_SW            = de1_io_pkg::N_SW,
    parameter int N_KEY           = de1_io_pkg::N_KEY,
    parameter int DEBOUNCE_CYCLES = de1_io_pkg::DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = de1_io_pkg::CNT_W
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_KEY-1:0] key_raw_n,
    input  logic [N_KEY-1:0] key_irq_mask,
    input  logic [N_KEY-1:0] key_ack,
    output logic [N_SW-1:0]  sw_stable,
    output logic [N_SW-1:0]  sw_change_pulse,
    output logic [N_KEY-1:0] key_pressed,
    output logic [N_KEY-1:0] key_press_pulse,
    output logic [N_KEY-1:0] key_pending,
    output logic             key_irq
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20) - 1) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES out of range 1..2^20-1");
    end
    if (CNT_W < de1_io_pkg::clog2(DEBOUNCE_CYCLES + 1)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .CYCLES    (DEBOUNCE_CYCLES),
            .WIDTH     (CNT_W),
            .SYNC_RESET(1'b0),
            .INVERT    (1'b0),
            .RISE_ONLY (1'b0)
        ) u_db (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .raw   (sw_raw[i]),
            .stable(sw_stable[i]),
            .pulse (sw_change_pulse[i])
        );
    end

    // Key synchronisers reset to the released (high) pin level so reset
    // never looks like a press.
    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        debounce_bit #(
            .CYCLES    (DEBOUNCE_CYCLES),
            .WIDTH     (CNT_W),
            .SYNC_RESET(1'b1),
            .INVERT    (1'b1),
            .RISE_ONLY (1'b1)
        ) u_db (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .raw   (key_raw_n[k]),
            .stable(key_pressed[k]),
            .pulse (key_press_pulse[k])
        );
    end

    // The press strobe wins over a coincident ack so no press is lost.
    logic [N_KEY-1:0] pending_next;

    always_comb begin
        pending_next = (key_pending & ~key_ack) | key_press_pulse;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            key_pending <= '0;
            key_irq     <= 1'b0;
        end else begin
            key_pending <= pending_next;
            key_irq     <= |(pending_next & key_irq_mask);
        end
    end

endmodule

// File: tb/tb_de1_input_conditioner.sv
// tb_de1_input_conditioner
//   Directed bench for de1_input_conditioner with DEBOUNCE_CYCLES=4: a
//   vector table for press/mask/ack behaviour plus hand-written sequences
//   for reset, bounce rejection, ack/press collision and reset mid-count.
module tb_de1_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_raw;
    logic [3:0] key_raw_n;
    logic [3:0] key_irq_mask;
    logic [3:0] key_ack;
    logic [7:0] sw_stable;
    logic [7:0] sw_change_pulse;
    logic [3:0] key_pressed;
    logic [3:0] key_press_pulse;
    logic [3:0] key_pending;
    logic       key_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    de1_input_conditioner #(
        .N_SW(8), .N_KEY(4), .DEBOUNCE_CYCLES(4), .CNT_W(20)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .sw_raw         (sw_raw),
        .key_raw_n      (key_raw_n),
        .key_irq_mask   (key_irq_mask),
        .key_ack        (key_ack),
        .sw_stable      (sw_stable),
        .sw_change_pulse(sw_change_pulse),
        .key_pressed    (key_pressed),
        .key_press_pulse(key_press_pulse),
        .key_pending    (key_pending),
        .key_irq        (key_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic [3:0] key_n;
        logic [3:0] mask;
        logic [3:0] ack;
        int         ticks;
        logic [7:0] e_sws;
        logic [7:0] e_swp;
        logic [3:0] e_kp;
        logic [3:0] e_kpp;
        logic [3:0] e_pend;
        logic       e_irq;
    } vec_t;

    vec_t vecs[17];

    // Advance one rising edge and settle away from it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] sws, input logic [7:0] swp,
                              input logic [3:0] kp, input logic [3:0] kpp,
                              input logic [3:0] pend, input logic irq);
        check({tag, ".sw_stable"},       sw_stable,             sws);
        check({tag, ".sw_change_pulse"}, sw_change_pulse,       swp);
        check({tag, ".key_pressed"},     {4'h0, key_pressed},     {4'h0, kp});
        check({tag, ".key_press_pulse"}, {4'h0, key_press_pulse}, {4'h0, kpp});
        check({tag, ".key_pending"},     {4'h0, key_pending},     {4'h0, pend});
        check({tag, ".key_irq"},         {7'h0, key_irq},         {7'h0, irq});
    endtask

    initial begin
        // Starting state: sw_stable=A5, no keys, mask=F.
        vecs[0]  = '{8'hA5, 4'hF, 4'hF, 4'h0, 1, 8'hA5, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{8'hA5, 4'hB, 4'hF, 4'h0, 5, 8'hA5, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{8'hA5, 4'hB, 4'hF, 4'h0, 1, 8'hA5, 8'h00, 4'h4, 4'h4, 4'h0, 1'b0};
        vecs[3]  = '{8'hA5, 4'hB, 4'hF, 4'h0, 1, 8'hA5, 8'h00, 4'h4, 4'h0, 4'h4, 1'b1};
        vecs[4]  = '{8'hA5, 4'hB, 4'hF, 4'h4, 1, 8'hA5, 8'h00, 4'h4, 4'h0, 4'h0, 1'b0};
        vecs[5]  = '{8'hA5, 4'hF, 4'hF, 4'h0, 5, 8'hA5, 8'h00, 4'h4, 4'h0, 4'h0, 1'b0};
        vecs[6]  = '{8'hA5, 4'hF, 4'hF, 4'h0, 1, 8'hA5, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{8'h5A, 4'h6, 4'hF, 4'h0, 5, 8'hA5, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[8]  = '{8'h5A, 4'h6, 4'hF, 4'h0, 1, 8'h5A, 8'hFF, 4'h9, 4'h9, 4'h0, 1'b0};
        vecs[9]  = '{8'h5A, 4'h6, 4'hF, 4'h0, 1, 8'h5A, 8'h00, 4'h9, 4'h0, 4'h9, 1'b1};
        vecs[10] = '{8'h5A, 4'h6, 4'h0, 4'h0, 1, 8'h5A, 8'h00, 4'h9, 4'h0, 4'h9, 1'b0};
        vecs[11] = '{8'h5A, 4'h6, 4'h8, 4'h0, 1, 8'h5A, 8'h00, 4'h9, 4'h0, 4'h9, 1'b1};
        vecs[12] = '{8'h5A, 4'h6, 4'h8, 4'h1, 1, 8'h5A, 8'h00, 4'h9, 4'h0, 4'h8, 1'b1};
        vecs[13] = '{8'h5A, 4'h6, 4'h8, 4'h8, 1, 8'h5A, 8'h00, 4'h9, 4'h0, 4'h0, 1'b0};
        vecs[14] = '{8'h5A, 4'h6, 4'hF, 4'h2, 1, 8'h5A, 8'h00, 4'h9, 4'h0, 4'h0, 1'b0};
        vecs[15] = '{8'h5A, 4'hF, 4'hF, 4'h0, 5, 8'h5A, 8'h00, 4'h9, 4'h0, 4'h0, 1'b0};
        vecs[16] = '{8'h5A, 4'hF, 4'hF, 4'h0, 1, 8'h5A, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0};

        // Reset with switches at A5 and keys released.
        rst          = 1'b1;
        sw_raw       = 8'hA5;
        key_raw_n    = 4'hF;
        key_irq_mask = 4'hF;
        key_ack      = 4'h0;
        tick(3);
        check_outs("in_reset", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        tick(5);
        check_outs("rst_rel_e5", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);
        check_outs("rst_rel_e6", 8'hA5, 8'hA5, 4'h0, 4'h0, 4'h0, 1'b0);

        for (int v = 0; v < 17; v++) begin
            sw_raw       = vecs[v].sw;
            key_raw_n    = vecs[v].key_n;
            key_irq_mask = vecs[v].mask;
            key_ack      = vecs[v].ack;
            tick(1);
            key_ack = 4'h0;
            tick(vecs[v].ticks - 1);
            check_outs($sformatf("vec%0d", v), vecs[v].e_sws, vecs[v].e_swp, vecs[v].e_kp,
                       vecs[v].e_kpp, vecs[v].e_pend, vecs[v].e_irq);
        end

        // Bounce on sw[0]: high for 3 samples, low for 1, then high.
        sw_raw = 8'h5B;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("bounce_hi%0d", i), sw_stable, 8'h5A);
            check($sformatf("bounce_hi%0d.pulse", i), sw_change_pulse, 8'h00);
        end
        sw_raw = 8'h5A;
        tick(1);
        check("bounce_lo", sw_stable, 8'h5A);
        sw_raw = 8'h5B;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("bounce_wait%0d", i), sw_stable, 8'h5A);
            check($sformatf("bounce_wait%0d.pulse", i), sw_change_pulse, 8'h00);
        end
        tick(1);
        check("bounce_accept", sw_stable, 8'h5B);
        check("bounce_accept.pulse", sw_change_pulse, 8'h01);
        tick(1);
        check("bounce_after.pulse", sw_change_pulse, 8'h00);

        // Ack colliding with a new press strobe on key 1.
        key_raw_n = 4'hD;
        tick(6);
        check_outs("k1_press1", 8'h5B, 8'h00, 4'h2, 4'h2, 4'h0, 1'b0);
        tick(1);
        check_outs("k1_pend1", 8'h5B, 8'h00, 4'h2, 4'h0, 4'h2, 1'b1);
        key_raw_n = 4'hF;
        tick(6);
        check_outs("k1_release", 8'h5B, 8'h00, 4'h0, 4'h0, 4'h2, 1'b1);
        key_raw_n = 4'hD;
        tick(6);
        check_outs("k1_press2", 8'h5B, 8'h00, 4'h2, 4'h2, 4'h2, 1'b1);
        key_ack = 4'h2;
        tick(1);
        key_ack = 4'h0;
        check_outs("k1_collide", 8'h5B, 8'h00, 4'h2, 4'h0, 4'h2, 1'b1);
        key_ack = 4'h2;
        tick(1);
        key_ack = 4'h0;
        check_outs("k1_lone_ack", 8'h5B, 8'h00, 4'h2, 4'h0, 4'h0, 1'b0);

        // Reset while key 0 is mid-count (cnt=2), key 1 held throughout.
        key_raw_n = 4'hC;
        tick(4);
        check("midcnt_pre.key_pressed", {4'h0, key_pressed}, 8'h02);
        rst = 1'b1;
        #1;
        check_outs("midcnt_async", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(2);
        check_outs("midcnt_hold", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        tick(5);
        check_outs("midcnt_e5", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);
        check_outs("midcnt_e6", 8'h5B, 8'h5B, 4'h3, 4'h3, 4'h0, 1'b0);
        tick(1);
        check_outs("midcnt_pend", 8'h5B, 8'h00, 4'h3, 4'h0, 4'h3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
